mem_access_unit: RTL



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_align.sv | 80 ++++++++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared encodings for the MEM stage (store/load types, FSM states)
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_t;

  // Encodings 110/111 are reserved and behave as "no load".
  function automatic logic is_load(input logic [2:0] ld);
    return (ld >= LD_LB) && (ld <= LD_LW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// mem_access_unit_if : req/ready data-memory bus between MEM stage and memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// mem_align : store lane steering, load extraction/extension, misalign check
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  write_mem,
  input  logic [2:0]  read_mem,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (write_mem)
      ST_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{rs2_data[7:0]}};
      end
      ST_SH: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{rs2_data[15:0]}};
      end
      ST_SW: begin
        wstrb = 4'b1111;
        wdata = rs2_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (read_mem)
      LD_LB:   load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  load_data = {24'h0, w_byte};
      LD_LH:   load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  load_data = {16'h0, w_half};
      default: load_data = rdata;
    endcase
  end

  // Store size decides alignment when both store and load are flagged.
  always_comb begin
    misalign = 1'b0;
    if (write_mem != ST_NONE) begin
      if (write_mem == ST_SH) misalign = addr_lo[0];
      else if (write_mem == ST_SW) misalign = |addr_lo;
    end else begin
      if (read_mem == LD_LH || read_mem == LD_LHU) misalign = addr_lo[0];
      else if (read_mem == LD_LW) misalign = |addr_lo;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : RV32I MEM stage - bus FSM, timeout, MEM/WB register
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    me_aluOut_WB_memOut,
  input  logic                    me_writeReg,
  input  logic [1:0]              me_writeMem,
  input  logic [2:0]              me_readMem,
  input  logic [31:0]             me_outAlu,
  input  logic [31:0]             me_rs2Data,
  input  logic [4:0]              me_rd,
  mem_access_unit_if.master       dmem,
  output logic                    mem_stall,
  output logic                    mem_misalign,
  output logic                    mem_fault,
  output logic                    wb_writeReg,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data
);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic        w_is_store;
  logic        w_access;
  logic        w_misalign;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;

  logic        w_stall;
  logic        w_start;
  logic        w_bad;
  logic        w_done;
  logic        w_timeout;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_misalign;
  logic        r_fault;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  assign w_is_store = (me_writeMem != ST_NONE);
  assign w_access   = w_is_store || is_load(me_readMem);
  assign w_cnt_inc  = r_cnt + 1'b1;

  mem_align u_align (
    .addr_lo   (me_outAlu[1:0]),
    .write_mem (me_writeMem),
    .read_mem  (me_readMem),
    .rs2_data  (me_rs2Data),
    .rdata     (dmem.dmem_rdata),
    .wstrb     (w_wstrb),
    .wdata     (w_wdata),
    .load_data (w_load_ext),
    .misalign  (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= MEM_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_bad       = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_access) begin
          if (w_misalign) begin
            w_bad = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        w_stall = 1'b1;
        // Ready wins over a timeout landing on the same cycle.
        if (dmem.dmem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = MEM_RESP;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = MEM_RESP;
        end
      end
      MEM_RESP: w_state_nxt = MEM_IDLE;
      default:  w_state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wstrb <= 4'h0;
      r_wdata <= 32'h0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= w_is_store;
      r_addr  <= {me_outAlu[31:2], 2'b00};
      r_wstrb <= w_wstrb;
      r_wdata <= w_wdata;
    end else if (w_done || w_timeout) begin
      r_req <= 1'b0;
      r_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_load_data <= 32'h0;
      r_misalign  <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_misalign <= w_bad;
      r_fault    <= w_timeout;
      if (r_state == MEM_REQ)
        r_cnt <= (w_done || w_timeout) ? '0 : w_cnt_inc;
      if (w_done)
        r_load_data <= w_load_ext;
    end
  end

  // r_fault is high exactly during the RESP cycle that follows a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= 5'h0;
      r_wb_data <= 32'h0;
    end else if (w_stall) begin
      r_wb_we <= 1'b0;
    end else begin
      r_wb_we   <= me_writeReg && !w_bad && !r_fault;
      r_wb_rd   <= me_rd;
      r_wb_data <= (me_aluOut_WB_memOut == WB_SEL_MEM) ? r_load_data : me_outAlu;
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wstrb = r_wstrb;
  assign dmem.dmem_wdata = r_wdata;

  assign mem_stall    = w_stall;
  assign mem_misalign = r_misalign;
  assign mem_fault    = r_fault;
  assign wb_writeReg  = r_wb_we;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;

endmodule

`default_nettype wire
